// File: rtl/trafficlight_controller_nway.sv
// trafficlight_controller_nway
//
// Purpose: gives right-of-way to NUM_DIRS conflicting approaches in
// round-robin order. Each approach cycles through GREEN, YELLOW and an
// all-red clearance. Phases are timed in ticks of an external timebase
// strobe. Approaches with no demand are skipped. GREEN is held while no
// other approach is waiting. A flashing-red fail-safe mode overrides
// everything except reset.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   tick        in   one-cycle timebase strobe; all dwell times count ticks
//   demand      in   [NUM_DIRS]  level request per approach
//   flash       in   level request for flashing-red mode
//   green       out  [NUM_DIRS]  green lamp per approach
//   yellow      out  [NUM_DIRS]  yellow lamp per approach
//   red         out  [NUM_DIRS]  red lamp per approach
//   active_dir  out  [$clog2(NUM_DIRS)]  approach holding right-of-way
//   phase       out  [2]  0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH
//
// Every output is decoded from registers only, so no input reaches an
// output through combinational logic.
module trafficlight_controller_nway #(
  parameter int NUM_DIRS     = 2,
  parameter int CNT_W        = 16,
  parameter int GREEN_TICKS  = 6000,
  parameter int YELLOW_TICKS = 500,
  parameter int ALLRED_TICKS = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [NUM_DIRS-1:0]         demand,
  input  logic                        flash,
  output logic [NUM_DIRS-1:0]         green,
  output logic [NUM_DIRS-1:0]         yellow,
  output logic [NUM_DIRS-1:0]         red,
  output logic [$clog2(NUM_DIRS)-1:0] active_dir,
  output logic [1:0]                  phase
);

  localparam int DIR_W = $clog2(NUM_DIRS);

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);

  logic [1:0]       state_q, state_d;
  logic [DIR_W-1:0] active_dir_q, active_dir_d;
  logic [DIR_W-1:0] next_dir_q, next_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_phase_q, flash_phase_d;
  // Set once GREEN has served its full minimum time. After that the
  // demand search runs on every clk, whether or not tick is high. Without
  // this flag, a green with sparse ticks could leave one tick early,
  // because cnt already sits at GREEN_LAST before the final tick.
  logic             green_hold_q, green_hold_d;

  // ------------------------------------------------------------------
  // Round-robin search for the next approach with demand.
  // The demand vector is rotated so that bit i maps to approach
  // (active_dir + i) mod NUM_DIRS. Bit 0 is the current approach and is
  // masked off. The lowest set bit above 0 is the nearest waiting
  // approach.
  // ------------------------------------------------------------------
  logic [NUM_DIRS-1:0] dem_others;
  logic                other_dem;
  logic [DIR_W-1:0]    sel_dir;
  logic [DIR_W:0]      sel_sum;

  always_comb begin
    dem_others = NUM_DIRS'({demand, demand} >> active_dir_q) & ~NUM_DIRS'(1);
    other_dem  = 1'b0;
    sel_sum    = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (dem_others[i]) begin
        other_dem = 1'b1;
        sel_sum   = {1'b0, active_dir_q} + (DIR_W + 1)'(i);
      end
    end
    if (sel_sum >= (DIR_W + 1)'(NUM_DIRS)) begin
      sel_sum = sel_sum - (DIR_W + 1)'(NUM_DIRS);
    end
    sel_dir = sel_sum[DIR_W-1:0];
  end

  // ------------------------------------------------------------------
  // One-hot decode of active_dir, shared by the lamp outputs.
  // ------------------------------------------------------------------
  logic [NUM_DIRS-1:0] dir_onehot;

  generate
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_onehot
      assign dir_onehot[gi] = (active_dir_q == DIR_W'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ALLRED;
      active_dir_q  <= '0;
      next_dir_q    <= '0;
      cnt_q         <= '0;
      flash_phase_q <= 1'b0;
      green_hold_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_dir_q  <= active_dir_d;
      next_dir_q    <= next_dir_d;
      cnt_q         <= cnt_d;
      flash_phase_q <= flash_phase_d;
      green_hold_q  <= green_hold_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    active_dir_d  = active_dir_q;
    next_dir_d    = next_dir_q;
    cnt_d         = cnt_q;
    flash_phase_d = flash_phase_q;
    green_hold_d  = green_hold_q;

    if (flash) begin
      // Fail-safe has priority over every timed transition.
      state_d      = ST_FLASH;
      green_hold_d = 1'b0;
      cnt_d        = '0;
      if (state_q != ST_FLASH) begin
        flash_phase_d = 1'b1;
      end else if (tick) begin
        flash_phase_d = ~flash_phase_q;
      end
    end else begin
      case (state_q)
        ST_GREEN: begin
          if (green_hold_q || (tick && cnt_q == GREEN_LAST)) begin
            if (other_dem) begin
              state_d      = ST_YELLOW;
              next_dir_d   = sel_dir;
              cnt_d        = '0;
              green_hold_d = 1'b0;
            end else begin
              // Nobody else is waiting. Keep green and search every clk.
              green_hold_d = 1'b1;
            end
          end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_YELLOW: begin
          if (tick) begin
            if (cnt_q == YELLOW_LAST) begin
              state_d = ST_ALLRED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        ST_ALLRED: begin
          if (tick) begin
            if (cnt_q == ALLRED_LAST) begin
              state_d      = ST_GREEN;
              active_dir_d = next_dir_q;
              cnt_d        = '0;
              green_hold_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          // Leaving FLASH: clear through a full all-red, then start at
          // approach 0.
          state_d    = ST_ALLRED;
          cnt_d      = '0;
          next_dir_d = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output decode (registers only)
  // ------------------------------------------------------------------
  always_comb begin
    green  = '0;
    yellow = '0;
    case (state_q)
      ST_GREEN:  green  = dir_onehot;
      ST_YELLOW: yellow = dir_onehot;
      default: ;
    endcase
    if (state_q == ST_FLASH) begin
      red = {NUM_DIRS{flash_phase_q}};
    end else begin
      red = ~(green | yellow);
    end
    active_dir = active_dir_q;
    phase      = state_q;
  end

endmodule
